// File: rtl/ram_bist_master_pkg.sv
// ram_bist_master_pkg: shared state/phase encodings and widths for the RAM BIST master.
`ifndef RAM_BIST_MASTER_PKG_SV
`define RAM_BIST_MASTER_PKG_SV
package ram_bist_master_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {W0, R0, W1, R1} phase_t;
    localparam int ERR_CNT_W = 8;
endpackage
`endif

// File: rtl/ram_bist_pattern.sv
// ram_bist_pattern: test pattern seed ^ addr, optionally complemented.
module ram_bist_pattern #(
    parameter int WIDTH = 8,
    parameter int AW = 8
) (
    input  logic [WIDTH-1:0] seed,
    input  logic [AW-1:0]    addr,
    input  logic             invert,
    output logic [WIDTH-1:0] pattern
);
    assign pattern = seed ^ WIDTH'(addr) ^ {WIDTH{invert}};
endmodule

// File: rtl/ram_bist_master.sv
// ram_bist_master: two-pass write/read-verify BIST over a single-port RAM request/ready interface.
module ram_bist_master
    import ram_bist_master_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int TIMEOUT = 15,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     seed,
    output logic                 request,
    output logic                 write_enable,
    output logic [AW-1:0]        addr,
    output logic [WIDTH-1:0]     write_data,
    input  logic [WIDTH-1:0]     read_data,
    input  logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic [AW-1:0]        fail_addr,
    output logic [WIDTH-1:0]     fail_expected,
    output logic [WIDTH-1:0]     fail_actual
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state, state_n;
    phase_t           phase;
    logic [WIDTH-1:0] seed_q, pat;
    logic [TW-1:0]    wait_cnt;
    logic             valid, last_addr, last_access, mismatch, expire;

    ram_bist_pattern #(.WIDTH(WIDTH), .AW(AW)) u_pattern (
        .seed(seed_q), .addr(addr), .invert(phase[1]), .pattern(pat)
    );

    assign last_addr   = addr == AW'(DEPTH - 1);
    assign last_access = last_addr && phase == R1;
    assign mismatch    = state == WAIT && ready && phase[0] && read_data != pat;
    assign expire      = state == WAIT && !ready && wait_cnt == TW'(TIMEOUT - 1);
    assign request     = state == REQ;
    assign busy        = state == REQ || state == WAIT;
    assign done        = state == DONE;
    assign write_data  = pat;
    // Result is visible during the done pulse and held afterwards until the next start.
    assign pass        = (done || valid) && error_count == '0 && !timeout;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? REQ : IDLE;
            REQ:     state_n = WAIT;
            WAIT:    state_n = ready ? (last_access ? DONE : REQ) : (expire ? DONE : WAIT);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase         <= W0;
            addr          <= '0;
            write_enable  <= 1'b0;
            seed_q        <= '0;
            wait_cnt      <= '0;
            timeout       <= 1'b0;
            valid         <= 1'b0;
            error_count   <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else begin
            if (state == IDLE && start) begin
                phase         <= W0;
                addr          <= '0;
                write_enable  <= 1'b1;
                seed_q        <= seed;
                timeout       <= 1'b0;
                valid         <= 1'b0;
                error_count   <= '0;
                fail_addr     <= '0;
                fail_expected <= '0;
                fail_actual   <= '0;
            end
            if (state == REQ) wait_cnt <= '0;
            if (state == WAIT && !ready) wait_cnt <= wait_cnt + 1'b1;
            if (expire) timeout <= 1'b1;
            if (state == DONE) valid <= 1'b1;
            if (state == WAIT && ready && !last_access) begin
                addr <= last_addr ? '0 : addr + 1'b1;
                if (last_addr) begin
                    phase        <= phase_t'(phase + 2'd1);
                    write_enable <= phase[0];
                end
            end
            if (mismatch) begin
                if (error_count != '1) error_count <= error_count + 1'b1;
                if (error_count == '0) begin
                    fail_addr     <= addr;
                    fail_expected <= pat;
                    fail_actual   <= read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_bist_master.sv
// tb_ram_bist_master: directed scenarios with a request-sequence scoreboard against behavioural RAM models.
module tb_ram_bist_master;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start16 = 1'b0, start256 = 1'b0;
    logic [7:0] seed16 = '0, seed256 = '0;
    logic       request16, we16, ready16 = 1'b0, busy16, done16, pass16, to16;
    logic [3:0] addr16, faddr16;
    logic [7:0] wdata16, rdata16 = '0, ecnt16, fexp16, fact16;
    logic       request256, we256, ready256 = 1'b0, busy256, done256, pass256, to256;
    logic [7:0] addr256, faddr256;
    logic [7:0] wdata256, rdata256 = '0, ecnt256, fexp256, fact256;
    logic [7:0] mem16 [16];
    logic [7:0] mem256 [256];
    int         fault = 0;
    int         acc = 0;
    int         errors = 0, checks = 0, extra = 0;
    logic [7:0] p_seed = '0, p_out;
    logic [3:0] p_addr = '0;
    logic       p_inv = 1'b0;

    typedef struct {logic we; logic [3:0] a; logic [7:0] d;} exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ram_bist_master #(.WIDTH(8), .DEPTH(16), .TIMEOUT(15)) u16 (
        .clk(clk), .reset(reset), .start(start16), .seed(seed16), .request(request16),
        .write_enable(we16), .addr(addr16), .write_data(wdata16), .read_data(rdata16),
        .ready(ready16), .busy(busy16), .done(done16), .pass(pass16), .timeout(to16),
        .error_count(ecnt16), .fail_addr(faddr16), .fail_expected(fexp16), .fail_actual(fact16)
    );

    ram_bist_master #(.WIDTH(8), .DEPTH(256), .TIMEOUT(15)) u256 (
        .clk(clk), .reset(reset), .start(start256), .seed(seed256), .request(request256),
        .write_enable(we256), .addr(addr256), .write_data(wdata256), .read_data(rdata256),
        .ready(ready256), .busy(busy256), .done(done256), .pass(pass256), .timeout(to256),
        .error_count(ecnt256), .fail_addr(faddr256), .fail_expected(fexp256), .fail_actual(fact256)
    );

    ram_bist_pattern #(.WIDTH(8), .AW(4)) u_pat (
        .seed(p_seed), .addr(p_addr), .invert(p_inv), .pattern(p_out)
    );

    // fault 1: bit 0 stuck-at-1 at addr 4; fault 2: access 5 never gets ready
    always @(posedge clk) begin
        ready16 <= 1'b0;
        acc <= busy16 ? (request16 ? acc + 1 : acc) : 0;
        if (request16) begin
            if (!(fault == 2 && acc == 5)) ready16 <= 1'b1;
            if (we16) mem16[addr16] <= wdata16;
            else rdata16 <= (fault == 1 && addr16 == 4'd4) ? (mem16[addr16] | 8'h01) : mem16[addr16];
        end
    end

    always @(posedge clk) begin
        ready256 <= request256;
        if (request256) begin
            if (we256) mem256[addr256] <= wdata256;
            else rdata256 <= ~mem256[addr256];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [7:0] s, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.we = ((i / 16) % 2) == 0;
            e.a  = 4'(i % 16);
            e.d  = s ^ {4'h0, e.a} ^ ((i / 16) >= 2 ? 8'hFF : 8'h00);
            q.push_back(e);
        end
    endtask

    task automatic go16(input logic [7:0] s);
        @(negedge clk);
        seed16 = s;
        start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic run_to_done(output int k);
        k = -1;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            if (done16) begin
                k = i;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (request16) begin
            if (q.size() == 0) extra++;
            else begin
                mon_e = q.pop_front();
                chk("req_we", we16, mon_e.we);
                chk("req_addr", addr16, mon_e.a);
                if (mon_e.we) chk("req_wdata", wdata16, mon_e.d);
            end
        end
    end

    initial begin
        int k, k2, kreq, nreq;
        p_seed = 8'hA5; p_addr = 4'd3; p_inv = 1'b0;
        #1 chk("pat_w0_a3", p_out, 8'hA6);
        p_inv = 1'b1;
        #1 chk("pat_r1_a3", p_out, 8'h59);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_request", request16, 0);
        chk("rst_we", we16, 0);
        chk("rst_addr", addr16, 0);
        chk("rst_wdata", wdata16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_pass", pass16, 0);
        chk("rst_timeout", to16, 0);
        chk("rst_errcnt", ecnt16, 0);
        chk("rst_fail", {faddr16, fexp16, fact16}, 0);
        reset = 1'b1;

        // clean run
        push_run(8'hA5, 64);
        go16(8'hA5);
        @(negedge clk);
        chk("clean_busy_t1", busy16, 1);
        chk("clean_req_t1", request16, 1);
        run_to_done(k);
        chk("clean_done_cycle", k + 1, 129);
        chk("clean_pass", pass16, 1);
        chk("clean_errcnt", ecnt16, 0);
        chk("clean_busy_done", busy16, 0);
        @(negedge clk);
        chk("clean_pass_hold", pass16, 1);
        chk("clean_queue", q.size(), 0);
        chk("clean_extra", extra, 0);

        // stuck bit
        fault = 1;
        push_run(8'h00, 64);
        go16(8'h00);
        run_to_done(k);
        chk("stuck_done_cycle", k, 129);
        chk("stuck_fail_addr", faddr16, 4);
        chk("stuck_fail_exp", fexp16, 8'h04);
        chk("stuck_fail_act", fact16, 8'h05);
        chk("stuck_errcnt", ecnt16, 1);
        chk("stuck_pass", pass16, 0);
        chk("stuck_queue", q.size(), 0);

        // ready stall on access 5
        fault = 2;
        push_run(8'h5A, 6);
        go16(8'h5A);
        nreq = 0; kreq = 0; k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            k = i;
            if (request16) begin
                nreq++;
                if (nreq == 6) kreq = i;
            end
            if (done16) break;
        end
        chk("stall_done_gap", k - kreq, 16);
        chk("stall_timeout", to16, 1);
        chk("stall_pass", pass16, 0);
        repeat (20) @(negedge clk);
        chk("stall_timeout_hold", to16, 1);
        chk("stall_extra", extra, 0);
        chk("stall_queue", q.size(), 0);
        fault = 0;

        // reset during R0 addr7
        push_run(8'h11, 64);
        go16(8'h11);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (request16 && !we16 && addr16 == 4'd7) begin
                k = 1;
                break;
            end
        end
        chk("rst_mid_found", k, 1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_request", request16, 0);
        chk("rst_mid_busy", busy16, 0);
        chk("rst_mid_done", done16, 0);
        q.delete();
        repeat (5) @(negedge clk);
        chk("rst_mid_idle", {request16, busy16, done16}, 0);
        push_run(8'h11, 64);
        go16(8'h11);
        run_to_done(k);
        chk("rerun_done_cycle", k, 129);
        chk("rerun_pass", pass16, 1);
        chk("rerun_errcnt", ecnt16, 0);
        chk("rerun_queue", q.size(), 0);

        // start held high: one run per IDLE acceptance
        push_run(8'h77, 64);
        push_run(8'h77, 64);
        @(negedge clk);
        seed16 = 8'h77;
        start16 = 1'b1;
        run_to_done(k);
        chk("hold_done1", k, 129);
        @(negedge clk);
        chk("hold_idle_gap", {request16, busy16, done16}, 0);
        @(posedge clk);
        #1 start16 = 1'b0;
        run_to_done(k2);
        chk("hold_done2", k2, 129);
        chk("hold_pass", pass16, 1);
        repeat (10) @(negedge clk);
        chk("hold_queue", q.size(), 0);
        chk("hold_extra", extra, 0);

        // all data inverted, DEPTH=256
        @(negedge clk);
        seed256 = 8'h3C;
        start256 = 1'b1;
        @(posedge clk);
        #1 start256 = 1'b0;
        k = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (done256) begin
                k = i;
                break;
            end
        end
        chk("sat_done_cycle", k, 2049);
        chk("sat_errcnt", ecnt256, 255);
        chk("sat_fail_addr", faddr256, 0);
        chk("sat_fail_exp", fexp256, 8'h3C);
        chk("sat_fail_act", fact256, 8'hC3);
        chk("sat_pass", pass256, 0);
        chk("sat_timeout", to256, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
